// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the register bank's single write port, plus a per-register busy scoreboard.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; without it the lowest valid index wins.
module regbank_wb_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int NUM_REQ       = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]  req_addr,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0] req_data,
  output logic                             wr_en,
  output logic [ADDRESS_SIZE-1:0]          wr_addr,
  output logic [REGISTER_SIZE-1:0]         wr_data,
  input  logic                             alloc_valid,
  input  logic [ADDRESS_SIZE-1:0]          alloc_addr,
  input  logic                             flush,
  input  logic [ADDRESS_SIZE-1:0]          rd_addr1,
  input  logic [ADDRESS_SIZE-1:0]          rd_addr2,
  output logic                             hazard1,
  output logic                             hazard2,
  output logic [(2**ADDRESS_SIZE)-1:0]     busy
);

  localparam int NUM_REGS = 2 ** ADDRESS_SIZE;
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDRESS_SIZE-1:0] ZERO_ADDR = {ADDRESS_SIZE{1'b0}};

  logic [NUM_REQ-1:0]       grant_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic                     grant_any_s;
  logic [ADDRESS_SIZE-1:0]  sel_addr_s;
  logic [REGISTER_SIZE-1:0] sel_data_s;
  logic                     wr_en_r;
  logic [ADDRESS_SIZE-1:0]  wr_addr_r;
  logic [REGISTER_SIZE-1:0] wr_data_r;
  logic [NUM_REGS-1:0]      busy_r;
  logic [NUM_REGS-1:0]      busy_nxt_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDX_W'(s);
  endfunction

  // Round-robin search starting at the pointer and wrapping past NUM_REQ-1.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {IDX_W{1'b0}};
    grant_any_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any_s && req_valid[wrap_idx(ptr_r, k)]) begin
        grant_any_s = 1'b1;
        grant_idx_s = wrap_idx(ptr_r, k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    grant_s[grant_idx_s] = grant_any_s;
  end

  // Pointer moves just past the winner after every handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (grant_any_s) begin
      ptr_r <= (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: the downward scan leaves the lowest valid index as winner.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_idx_s = {IDX_W{1'b0}};
    grant_any_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_any_s = 1'b1;
        grant_idx_s = IDX_W'(k);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    grant_s[grant_idx_s] = grant_any_s;
  end
`endif

  assign req_ready = grant_s;

  // Steer the winner's address and data slices toward the output stage.
  always_comb begin
    sel_addr_s = {ADDRESS_SIZE{1'b0}};
    sel_data_s = {REGISTER_SIZE{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        sel_addr_s = req_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
        sel_data_s = req_data[k*REGISTER_SIZE +: REGISTER_SIZE];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Output stage; writes to register 0 are consumed but never enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDRESS_SIZE{1'b0}};
      wr_data_r <= {REGISTER_SIZE{1'b0}};
    end else if (grant_any_s) begin
      wr_en_r   <= (sel_addr_s != ZERO_ADDR);
      wr_addr_r <= sel_addr_s;
      wr_data_r <= sel_data_s;
    end else begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= wr_addr_r;
      wr_data_r <= wr_data_r;
    end
  end

  // Scoreboard next state: a same-cycle set beats the clear; flush beats both.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = {NUM_REGS{1'b0}};
    end else begin
      if (wr_en_r) begin
        busy_nxt_s[wr_addr_r] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (alloc_valid && (alloc_addr != ZERO_ADDR)) begin
        busy_nxt_s[alloc_addr] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign busy    = busy_r;
  assign hazard1 = (rd_addr1 != ZERO_ADDR) && busy_r[rd_addr1];
  assign hazard2 = (rd_addr2 != ZERO_ADDR) && busy_r[rd_addr2];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter: expected writes are queued at issue and
// popped by a monitor whenever wr_en is seen; other checks are directed.
module tb_regbank_wb_arbiter;
  localparam int RS = 32;
  localparam int AS = 5;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*AS-1:0] req_addr = '0;
  logic [NR*RS-1:0] req_data = '0;
  logic wr_en;
  logic [AS-1:0] wr_addr;
  logic [RS-1:0] wr_data;
  logic alloc_valid = 1'b0;
  logic [AS-1:0] alloc_addr = '0;
  logic flush = 1'b0;
  logic [AS-1:0] rd_addr1 = '0;
  logic [AS-1:0] rd_addr2 = '0;
  logic hazard1, hazard2;
  logic [(2**AS)-1:0] busy;

  typedef struct packed {
    logic [AS-1:0] addr;
    logic [RS-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int n_checks = 0;
  int n_fail = 0;

  regbank_wb_arbiter #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .flush(flush), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AS-1:0] a, input logic [RS-1:0] d);
    case (i)
      0: begin req_addr[4:0]   = a; req_data[31:0]  = d; end
      1: begin req_addr[9:5]   = a; req_data[63:32] = d; end
      2: begin req_addr[14:10] = a; req_data[95:64] = d; end
      default: begin req_addr = req_addr; end
    endcase
  endtask

  task automatic expect_write(input logic [AS-1:0] a, input logic [RS-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every committed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: wr_en=1 addr %0d data 0x%h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        check("mon_wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        check("mon_wr_data", 64'(wr_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_idx [6];
`ifdef ARB_ROUND_ROBIN_EN
    exp_idx = '{0, 1, 2, 0, 1, 2};
`else
    exp_idx = '{0, 0, 0, 0, 0, 0};
`endif

    // Reset state; req_ready still follows req_valid during reset
    step();
    req_valid = 3'b010;
    step();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready_follows", 64'(req_ready), 64'd2);
    req_valid = 3'b000;
    step();
    reset = 1'b1;

    // Contention: all three requesters valid for six cycles
    step();
    set_req(0, 5'd11, 32'hA000_0000);
    set_req(1, 5'd12, 32'hA000_0001);
    set_req(2, 5'd13, 32'hA000_0002);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      case (exp_idx[c])
        0: expect_write(5'd11, 32'hA000_0000);
        1: expect_write(5'd12, 32'hA000_0001);
        default: expect_write(5'd13, 32'hA000_0002);
      endcase
      @(negedge clk);
      check($sformatf("contend_ready_%0d", c), 64'(req_ready), 64'(3'b001 << exp_idx[c]));
      step();
    end
    req_valid = 3'b000;

    // Single request from requester 1
    step();
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    expect_write(5'd7, 32'hDEADBEEF);
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'd2);
    step();
    req_valid = 3'b000;
    @(negedge clk);
    check("single_wr_en", 64'(wr_en), 64'd1);

    // Scoreboard: alloc 5, then write 5 retires it
    step();
    alloc_valid = 1'b1; alloc_addr = 5'd5; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    @(negedge clk);
    check("sb_c0_hazard1", 64'(hazard1), 64'd0);
    step();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("sb_c1_hazard1", 64'(hazard1), 64'd1);
    check("sb_c1_hazard2", 64'(hazard2), 64'd1);
    check("sb_c1_busy5", 64'(busy[5]), 64'd1);
    step();
    @(negedge clk);
    check("sb_c2_hazard1", 64'(hazard1), 64'd1);
    step();
    set_req(0, 5'd5, 32'h0000_0055);
    req_valid = 3'b001;
    expect_write(5'd5, 32'h0000_0055);
    @(negedge clk);
    check("sb_c3_hazard1", 64'(hazard1), 64'd1);
    step();
    req_valid = 3'b000;
    @(negedge clk);
    check("sb_c4_hazard1", 64'(hazard1), 64'd1);
    step();
    @(negedge clk);
    check("sb_c5_hazard1", 64'(hazard1), 64'd0);
    check("sb_c5_busy5", 64'(busy[5]), 64'd0);

    // Same-cycle set and clear on 9, then flush (flush also beats an alloc of 3)
    step();
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    step();
    alloc_valid = 1'b0;
    set_req(2, 5'd9, 32'h0000_0099);
    req_valid = 3'b100;
    expect_write(5'd9, 32'h0000_0099);
    step();
    req_valid = 3'b000;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    step();
    alloc_valid = 1'b1; alloc_addr = 5'd3; flush = 1'b1;
    @(negedge clk);
    check("setclr_busy9", 64'(busy[9]), 64'd1);
    step();
    alloc_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);

    // Register 0: grant consumed, no write enable, never busy
    step();
    set_req(2, 5'd0, 32'h0000_1234);
    req_valid = 3'b100;
    alloc_valid = 1'b1; alloc_addr = 5'd0; rd_addr1 = 5'd0;
    @(negedge clk);
    check("r0_ready", 64'(req_ready), 64'd4);
    step();
    req_valid = 3'b000; alloc_valid = 1'b0;
    @(negedge clk);
    check("r0_wr_en", 64'(wr_en), 64'd0);
    check("r0_wr_addr", 64'(wr_addr), 64'd0);
    check("r0_wr_data", 64'(wr_data), 64'h1234);
    check("r0_busy0", 64'(busy[0]), 64'd0);
    check("r0_hazard1", 64'(hazard1), 64'd0);

    // Reset asserted mid-stream while wr_en=1
    step();
    alloc_valid = 1'b1; alloc_addr = 5'd20; rd_addr1 = 5'd20; rd_addr2 = 5'd20;
    step();
    alloc_valid = 1'b0;
    set_req(1, 5'd6, 32'hCAFEF00D);
    req_valid = 3'b010;
    expect_write(5'd6, 32'hCAFEF00D);
    step();
    req_valid = 3'b000;
    check("mid_wr_en_before", 64'(wr_en), 64'd1);
    check("mid_busy20_before", 64'(busy[20]), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_wr_en", 64'(wr_en), 64'd0);
    check("mid_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_wr_data", 64'(wr_data), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_hazard1", 64'(hazard1), 64'd0);
    check("mid_hazard2", 64'(hazard2), 64'd0);
    sb.delete();
    step();
    reset = 1'b1;

    // After reset the arbiter restarts from requester 0
    step();
    set_req(0, 5'd17, 32'h1700_0000);
    set_req(1, 5'd18, 32'h1800_0000);
    set_req(2, 5'd19, 32'h1900_0000);
    req_valid = 3'b111;
    expect_write(5'd17, 32'h1700_0000);
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 3'b000;
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
